muldiv_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit for the EX stage, feeding the HI/LO register.

---
 rtl/muldiv_unit.sv | 205 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: shift-add MULT/MULTU, restoring DIV/DIVU,
// with an optional single-cycle multiply, flush/cancel and a fixed divide-by-zero result.
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter bit MUL_FAST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } stateT;

  stateT state, stateNext;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       opReg;
  logic [WIDTH-1:0] operandReg;
  logic [WIDTH-1:0] accHi;
  logic [WIDTH-1:0] accLo;
  logic             negRes;
  logic             negRem;
  logic             divZeroReg;

  // Operand decode: op[1] selects divide, op[0]==0 selects a signed operation.
  logic             isSignedIn;
  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic             bZero;
  logic             takeStart;
  logic             fastPath;

  assign isSignedIn = ~op[0];
  assign aNeg       = isSignedIn & a[WIDTH-1];
  assign bNeg       = isSignedIn & b[WIDTH-1];
  assign aMag       = aNeg ? -a : a;
  assign bMag       = bNeg ? -b : b;
  assign bZero      = (b == '0);
  assign takeStart  = (state == IDLE) & start & ~flush;
  assign fastPath   = (MUL_FAST & ~op[1]) | (op[1] & bZero);

  // Single-cycle results: full-width product, or the divide-by-zero pattern.
  logic [2*WIDTH-1:0] fastProd;
  logic [2*WIDTH-1:0] fastProdSigned;
  logic [WIDTH-1:0]   fastHi;
  logic [WIDTH-1:0]   fastLo;
  logic               fastDivZero;

  assign fastProd       = {{WIDTH{1'b0}}, aMag} * {{WIDTH{1'b0}}, bMag};
  assign fastProdSigned = (aNeg ^ bNeg) ? -fastProd : fastProd;

  always_comb begin
    fastHi      = fastProdSigned[2*WIDTH-1:WIDTH];
    fastLo      = fastProdSigned[WIDTH-1:0];
    fastDivZero = 1'b0;
    if (op[1]) begin
      fastHi      = a;
      fastLo      = '1;
      fastDivZero = 1'b1;
    end
  end

  // One multiply step: conditionally add the multiplicand to the upper half, then shift
  // {carry, accHi, accLo} right so the multiplier bits drain out of accLo.
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHi;
  logic [WIDTH-1:0] mulLo;

  assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, operandReg} : '0);
  assign mulHi  = mulSum[WIDTH:1];
  assign mulLo  = {mulSum[0], accLo[WIDTH-1:1]};

  // One restoring divide step: accHi is the partial remainder, accLo shifts the dividend
  // out at the top and the quotient bits in at the bottom.
  logic [WIDTH:0]   divShift;
  logic [WIDTH:0]   divTrial;
  logic             divOk;
  logic [WIDTH-1:0] divHi;
  logic [WIDTH-1:0] divLo;

  assign divShift = {accHi, accLo[WIDTH-1]};
  assign divTrial = divShift - {1'b0, operandReg};
  assign divOk    = ~divTrial[WIDTH];
  assign divHi    = divOk ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
  assign divLo    = {accLo[WIDTH-2:0], divOk};

  logic [WIDTH-1:0] iterHi;
  logic [WIDTH-1:0] iterLo;

  assign iterHi = opReg[1] ? divHi : mulHi;
  assign iterLo = opReg[1] ? divLo : mulLo;

  // Sign restoration applied on the last iteration, as the result is registered.
  logic [2*WIDTH-1:0] mulFinal;
  logic [WIDTH-1:0]   finalHi;
  logic [WIDTH-1:0]   finalLo;

  assign mulFinal = negRes ? -{iterHi, iterLo} : {iterHi, iterLo};

  always_comb begin
    finalHi = mulFinal[2*WIDTH-1:WIDTH];
    finalLo = mulFinal[WIDTH-1:0];
    if (opReg[1]) begin
      finalHi = negRem ? -iterHi : iterHi;
      finalLo = negRes ? -iterLo : iterLo;
    end
  end

  // Next-state logic; flush returns to IDLE from any state and beats a same-cycle start.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (takeStart) begin
          stateNext = fastPath ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_W'(1)) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
    if (flush) begin
      stateNext = IDLE;
    end
  end

  // State, datapath and result registers; results only change when entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      opReg      <= '0;
      operandReg <= '0;
      accHi      <= '0;
      accLo      <= '0;
      negRes     <= 1'b0;
      negRem     <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      divZeroReg <= 1'b0;
    end else begin
      state <= stateNext;
      if (takeStart) begin
        opReg  <= op;
        negRes <= aNeg ^ bNeg;
        negRem <= aNeg;
        cnt    <= CNT_W'(WIDTH);
        accHi  <= '0;
        if (op[1]) begin
          operandReg <= bMag;
          accLo      <= aMag;
        end else begin
          operandReg <= aMag;
          accLo      <= bMag;
        end
        if (fastPath) begin
          hi         <= fastHi;
          lo         <= fastLo;
          divZeroReg <= fastDivZero;
        end
      end else if ((state == CALC) && !flush) begin
        cnt   <= cnt - CNT_W'(1);
        accHi <= iterHi;
        accLo <= iterLo;
        if (cnt == CNT_W'(1)) begin
          hi         <= finalHi;
          lo         <= finalLo;
          divZeroReg <= 1'b0;
        end
      end
    end
  end

  assign busy     = (state == CALC);
  assign done     = (state == DONE);
  assign div_zero = done & divZeroReg;
  assign stall    = takeStart | (state == CALC);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: three instances (32-bit iterative, 32-bit fast multiply, 8-bit
// iterative) share one stimulus stream and are checked against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        startIn;
  logic        flushIn;
  logic [1:0]  opIn;
  logic [31:0] aIn;
  logic [31:0] bIn;

  logic        stall0, busy0, done0, dz0;
  logic [31:0] hi0, lo0;
  logic        stall1, busy1, done1, dz1;
  logic [31:0] hi1, lo1;
  logic        stall2, busy2, done2, dz2;
  logic [7:0]  hi2, lo2;

  int compared   = 0;
  int mismatched = 0;
  int opNum      = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .MUL_FAST(1'b0)) dutSlow (
    .clk(clk), .rst(rst), .start(startIn), .op(opIn), .a(aIn), .b(bIn), .flush(flushIn),
    .stall(stall0), .busy(busy0), .done(done0), .hi(hi0), .lo(lo0), .div_zero(dz0)
  );

  muldiv_unit #(.WIDTH(32), .MUL_FAST(1'b1)) dutFast (
    .clk(clk), .rst(rst), .start(startIn), .op(opIn), .a(aIn), .b(bIn), .flush(flushIn),
    .stall(stall1), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1), .div_zero(dz1)
  );

  muldiv_unit #(.WIDTH(8), .MUL_FAST(1'b0)) dutNarrow (
    .clk(clk), .rst(rst), .start(startIn), .op(opIn), .a(aIn[7:0]), .b(bIn[7:0]), .flush(flushIn),
    .stall(stall2), .busy(busy2), .done(done2), .hi(hi2), .lo(lo2), .div_zero(dz2)
  );

  // Compare one observed value with its expectation and count the outcome.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference result of one operation of width w, straight from signed/unsigned arithmetic.
  function automatic void refModel(input int w, input bit fast, input logic [1:0] op,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eHi, output logic [31:0] eLo,
                                   output logic eDz, output int eLat);
    longint unsigned mask, ua, ub, up;
    longint          sa, sb, sp;
    bit              isSigned;
    mask     = (64'd1 << w) - 64'd1;
    ua       = {32'd0, a} & mask;
    ub       = {32'd0, b} & mask;
    isSigned = !op[0];
    sa       = (isSigned && ua[w-1]) ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb       = (isSigned && ub[w-1]) ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    eDz      = 1'b0;
    if (op[1]) begin
      if (ub == 0) begin
        eHi  = 32'(ua);
        eLo  = 32'(mask);
        eDz  = 1'b1;
        eLat = 1;
      end else begin
        if (isSigned) begin
          eLo = 32'(longint'(sa / sb) & longint'(mask));
          eHi = 32'(longint'(sa % sb) & longint'(mask));
        end else begin
          eLo = 32'((ua / ub) & mask);
          eHi = 32'((ua % ub) & mask);
        end
        eLat = w + 1;
      end
    end else begin
      if (isSigned) begin
        sp = sa * sb;
        up = longint'(sp);
      end else begin
        up = ua * ub;
      end
      eLo  = 32'(up & mask);
      eHi  = 32'((up >> w) & mask);
      eLat = fast ? 1 : w + 1;
    end
  endfunction

  // Issue one operation to all three instances and check latency, stall, done pulse and result.
  // With poke set, start is re-asserted mid-operation and must be ignored.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
    int          lat[3];
    int          doneCnt[3];
    int          stallCnt[3];
    logic [31:0] gotHi[3], gotLo[3];
    logic        gotDz[3];
    logic [31:0] eHi[3], eLo[3];
    logic        eDz[3];
    int          eLat[3];
    logic        dn[3], st[3], zz[3];
    logic [31:0] hh[3], ll[3];
    opNum++;
    refModel(32, 1'b0, op, a, b, eHi[0], eLo[0], eDz[0], eLat[0]);
    refModel(32, 1'b1, op, a, b, eHi[1], eLo[1], eDz[1], eLat[1]);
    refModel(8,  1'b0, op, a, b, eHi[2], eLo[2], eDz[2], eLat[2]);
    for (int d = 0; d < 3; d++) begin
      lat[d] = -1; doneCnt[d] = 0; stallCnt[d] = 0;
      gotHi[d] = '0; gotLo[d] = '0; gotDz[d] = 1'b0;
    end
    @(negedge clk);
    opIn = op; aIn = a; bIn = b; startIn = 1'b1;
    #1;
    for (int k = 0; k < 36; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (k == 1) begin
          aIn = $urandom; bIn = $urandom; opIn = 2'($urandom);
        end
        startIn = poke && (k == 3);
        #1;
      end
      dn[0] = done0; st[0] = stall0; hh[0] = hi0; ll[0] = lo0; zz[0] = dz0;
      dn[1] = done1; st[1] = stall1; hh[1] = hi1; ll[1] = lo1; zz[1] = dz1;
      dn[2] = done2; st[2] = stall2; hh[2] = {24'd0, hi2}; ll[2] = {24'd0, lo2}; zz[2] = dz2;
      for (int d = 0; d < 3; d++) begin
        if (lat[d] < 0 && st[d] === 1'b1) stallCnt[d]++;
        if (dn[d] === 1'b1) begin
          doneCnt[d]++;
          if (lat[d] < 0) begin
            lat[d] = k; gotHi[d] = hh[d]; gotLo[d] = ll[d]; gotDz[d] = zz[d];
          end
        end
      end
    end
    startIn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("op%0d dut%0d latency", opNum, d), 64'(lat[d]), 64'(eLat[d]));
      checkOutput($sformatf("op%0d dut%0d doneCount", opNum, d), 64'(doneCnt[d]), 64'd1);
      checkOutput($sformatf("op%0d dut%0d stallCycles", opNum, d), 64'(stallCnt[d]), 64'(eLat[d]));
      checkOutput($sformatf("op%0d dut%0d hi", opNum, d), {32'd0, gotHi[d]}, {32'd0, eHi[d]});
      checkOutput($sformatf("op%0d dut%0d lo", opNum, d), {32'd0, gotLo[d]}, {32'd0, eLo[d]});
      checkOutput($sformatf("op%0d dut%0d divZero", opNum, d), {63'd0, gotDz[d]}, {63'd0, eDz[d]});
    end
  endtask

  function automatic logic [31:0] pickValue();
    logic [31:0] specials [6];
    specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000080};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] prevHi0, prevLo0, prevHi1, prevLo1;
    int          lateDone;

    rst = 1'b1; startIn = 1'b0; flushIn = 1'b0; opIn = 2'b00; aIn = '0; bIn = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset hi0", {32'd0, hi0}, 64'd0);
    checkOutput("reset lo0", {32'd0, lo0}, 64'd0);
    checkOutput("reset flags0", {60'd0, done0, busy0, dz0, stall0}, 64'd0);
    checkOutput("reset hi1lo1", {hi1, lo1}, 64'd0);
    checkOutput("reset flags1", {60'd0, done1, busy1, dz1, stall1}, 64'd0);
    checkOutput("reset dut2", {44'd0, hi2, lo2, done2, busy2, dz2, stall2}, 64'd0);

    // Directed operations from the feature list.
    applyStimulus(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0);
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, 1'b1);
    applyStimulus(2'b11, 32'hFFFFFFFF, 32'h10, 1'b0);
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    applyStimulus(2'b11, 32'h1234, 32'h0, 1'b0);
    applyStimulus(2'b00, 32'h80, 32'h80, 1'b0);
    applyStimulus(2'b10, 32'h7FFFFFFF, 32'h0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      applyStimulus(2'($urandom), pickValue(), pickValue(), 1'b0);
    end

    // Flush ten cycles into a divide: no done, results unchanged.
    applyStimulus(2'b01, 32'h1234_5678, 32'h0000_9ABC, 1'b0);
    prevHi0 = hi0; prevLo0 = lo0; prevHi1 = hi1; prevLo1 = lo1;
    @(negedge clk);
    opIn = 2'b10; aIn = 32'd1000; bIn = 32'd7; startIn = 1'b1;
    lateDone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      startIn = 1'b0;
      flushIn = (k == 10);
      #1;
      if (k == 11) begin
        checkOutput("flush busy", {62'd0, busy0, busy1}, 64'd0);
        checkOutput("flush stall", {62'd0, stall0, stall1}, 64'd0);
      end
      if (k >= 10 && (done0 === 1'b1 || done1 === 1'b1)) lateDone++;
    end
    flushIn = 1'b0;
    checkOutput("flush noDone", 64'(lateDone), 64'd0);
    checkOutput("flush keep0", {hi0, lo0}, {prevHi0, prevLo0});
    checkOutput("flush keep1", {hi1, lo1}, {prevHi1, prevLo1});

    // Start and flush together: the operation is not accepted.
    @(negedge clk);
    opIn = 2'b00; aIn = 32'd9; bIn = 32'd9; startIn = 1'b1; flushIn = 1'b1;
    #1;
    checkOutput("startFlush stall", {61'd0, stall0, stall1, stall2}, 64'd0);
    lateDone = 0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      startIn = 1'b0; flushIn = 1'b0;
      #1;
      if (k == 1) checkOutput("startFlush busy", {61'd0, busy0, busy1, busy2}, 64'd0);
      if (done0 === 1'b1 || done1 === 1'b1 || done2 === 1'b1) lateDone++;
    end
    checkOutput("startFlush noDone", 64'(lateDone), 64'd0);

    // Reset while calculating returns every output to its reset value.
    applyStimulus(2'b11, 32'hDEAD_BEEF, 32'h0000_0013, 1'b0);
    @(negedge clk);
    opIn = 2'b10; aIn = 32'd100; bIn = 32'd7; startIn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      startIn = 1'b0;
    end
    #1;
    checkOutput("preReset busy", {61'd0, busy0, busy1, busy2}, 64'h7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midReset hilo0", {hi0, lo0}, 64'd0);
    checkOutput("midReset hilo1", {hi1, lo1}, 64'd0);
    checkOutput("midReset dut2", {48'd0, hi2, lo2}, 64'd0);
    checkOutput("midReset flags", {52'd0, done0, busy0, dz0, stall0, done1, busy1, dz1, stall1,
                                   done2, busy2, dz2, stall2}, 64'd0);
    lateDone = 0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      #1;
      if (done0 === 1'b1 || done1 === 1'b1 || done2 === 1'b1) lateDone++;
    end
    checkOutput("midReset noDone", 64'(lateDone), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
